// File: rtl/nibble_serial_pkg.sv
// Shared types for the nibble-serial adder.
// Holds the FSM state encoding and the slice width.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// Full_Adder4: 4-bit ripple-carry adder slice.
// Ports: a, b, cin in; s (4-bit sum), cout out.
module Full_Adder4
    import nibble_serial_pkg::*;
(
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add, one nibble per clock.
// Ports: clk, rst (sync, high), start, a, b, cin in;
//        busy, done, s, cout, ovf out.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_s;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic [IDX_W-1:0]    r_idx;

    logic                w_load;
    logic                w_last;
    logic [NIBBLE_W-1:0] w_fa_a;
    logic [NIBBLE_W-1:0] w_fa_b;
    logic [NIBBLE_W-1:0] w_fa_s;
    logic                w_fa_c;

    assign w_last = (r_idx == IDX_W'(N - 1));
    assign w_fa_a = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_fa_b = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

    Full_Adder4 u_fa (
        .s    (w_fa_s),
        .cout (w_fa_c),
        .a    (w_fa_a),
        .b    (w_fa_b),
        .cin  (r_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_s     <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_s[NIBBLE_W*r_idx +: NIBBLE_W] <= w_fa_s;
            r_carry <= w_fa_c;
            if (w_last) begin
                r_cout <= w_fa_c;
                // top slice sum bit is the result MSB
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_fa_s[NIBBLE_W-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks for nibble_serial_adder.
// WIDTH=16, so each add takes 4 RUN cycles plus 1 DONE.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int n_chk  = 0;
    int n_pass = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one add at a negedge and wait for done.
    // Returns at the negedge inside the DONE cycle.
    task automatic do_add(input string tag,
                          input logic [15:0] ia,
                          input logic [15:0] ib,
                          input logic        ic,
                          input logic [15:0] es,
                          input logic        ec,
                          input logic        eo);
        int lat;
        int nbusy;
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},  lat,   5);
        check({tag, "_busy"}, nbusy, 4);
        check({tag, "_s"},    s,     es);
        check({tag, "_cout"}, cout,  ec);
        check({tag, "_ovf"},  ovf,   eo);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] gold;
        logic        gov;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s",    s,    0);
        check("rst_cout", cout, 0);
        check("rst_ovf",  ovf,  0);
        rst = 1'b0;
        @(negedge clk);

        // 1) basic add, then s must hold after done
        do_add("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        a = 16'hAAAA;
        b = 16'hAAAA;
        repeat (3) @(negedge clk);
        check("t1_hold_s",    s,    16'h5555);
        check("t1_hold_done", done, 0);

        // 2) carry ripples through every nibble
        do_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);

        // 3) signed overflow both directions
        do_add("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        do_add("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        do_add("t3c", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);

        // 4) start in RUN ignored; start in DONE accepted
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_done", done, 1);
        check("t4_s",    s,    16'h0002);
        do_add("t4b", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        start = 1'b1;
        a     = 16'h0010;
        b     = 16'h0020;
        @(negedge clk);
        start = 1'b0;
        check("t4_bb_busy", busy, 1);
        repeat (4) @(negedge clk);
        check("t4_bb_done", done, 1);
        check("t4_bb_s",    s,    16'h0030);
        @(negedge clk);

        // 5) reset in the second RUN cycle aborts the add
        a     = 16'h1234;
        b     = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_s",    s,    0);
        check("t5_cout", cout, 0);
        begin
            int seen = 0;
            repeat (6) begin
                if (done) seen++;
                @(negedge clk);
            end
            check("t5_nodone", seen, 0);
        end
        do_add("t5b", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // 6) random back-to-back adds against a+b+cin
        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            gold = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            gov  = (ra[15] == rb[15]) && (gold[15] != ra[15]);
            do_add("rnd", ra, rb, rc, gold[15:0], gold[16], gov);
            if (i % 50 == 0) begin
                @(negedge clk);
                @(negedge clk);
                check("rnd_hold", s, gold[15:0]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
